// File: rtl/snoop_bus_arbiter_if.sv
// snoop_bus_arbiter_if
// Bundles the request, snoop-broadcast and completion signals that run
// between the per-core cache controllers and the snoop bus arbiter.
//   req_valid/req_type/req_addr   : per-core coherence requests
//   req_grant                     : one-hot acceptance pulse
//   snoop_valid/type/addr/mask    : broadcast of the granted request
//   snoop_ack/hit/provide         : per-core snoop responses
//   done_*                        : completion returned to the requester
// Modports: slave = arbiter side, master = cache-controller side.
interface snoop_bus_arbiter_if #(
    parameter int NCORES = 4,
    parameter int ADDR_W = 64
);
    localparam int ID_W = (NCORES > 1) ? $clog2(NCORES) : 1;

    logic [NCORES-1:0]        req_valid;
    logic [2*NCORES-1:0]      req_type;
    logic [ADDR_W*NCORES-1:0] req_addr;
    logic [NCORES-1:0]        req_grant;
    logic                     snoop_valid;
    logic [1:0]               snoop_type;
    logic [ADDR_W-1:0]        snoop_addr;
    logic [NCORES-1:0]        snoop_mask;
    logic [NCORES-1:0]        snoop_ack;
    logic [NCORES-1:0]        snoop_hit;
    logic [NCORES-1:0]        snoop_provide;
    logic [NCORES-1:0]        done_valid;
    logic [ID_W-1:0]          done_supplier;
    logic                     done_from_mem;
    logic                     done_shared;
    logic                     done_timeout;

    modport slave (
        input  req_valid, req_type, req_addr,
        input  snoop_ack, snoop_hit, snoop_provide,
        output req_grant,
        output snoop_valid, snoop_type, snoop_addr, snoop_mask,
        output done_valid, done_supplier, done_from_mem, done_shared, done_timeout
    );

    modport master (
        output req_valid, req_type, req_addr,
        output snoop_ack, snoop_hit, snoop_provide,
        input  req_grant,
        input  snoop_valid, snoop_type, snoop_addr, snoop_mask,
        input  done_valid, done_supplier, done_from_mem, done_shared, done_timeout
    );
endinterface

// File: rtl/snoop_bus_arbiter.sv
// snoop_bus_arbiter
// Serialises coherence requests from NCORES private MOESI caches onto one
// shared snoop bus. A round-robin winner is latched, broadcast to all other
// cores, their responses are collected, and a single completion naming the
// data supplier (or memory) is returned to the requester.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : snoop_bus_arbiter_if.slave (requests, snoop broadcast/responses,
//           completion)
module snoop_bus_arbiter #(
    parameter int NCORES        = 4,
    parameter int ADDR_W        = 64,
    parameter int SNOOP_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    snoop_bus_arbiter_if.slave bus
);
    localparam int         ID_W         = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam logic [1:0] TYPE_READ    = 2'b01;
    localparam logic [1:0] TYPE_UPGRADE = 2'b11;
    localparam logic [7:0] TIMEOUT_CNT  = 8'(SNOOP_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SNOOP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ID_W-1:0]     r_winner;
    logic [ID_W-1:0]     r_last;
    logic [1:0]          r_type;
    logic [ADDR_W-1:0]   r_addr;
    logic [NCORES-1:0]   r_mask;
    logic [NCORES-1:0]   r_ack;
    logic [NCORES-1:0]   r_hit;
    logic [NCORES-1:0]   r_prov;
    logic [7:0]          r_cnt;
    logic [NCORES-1:0]   r_grant;
    logic [NCORES-1:0]   r_done_valid;
    logic [ID_W-1:0]     r_supplier;
    logic                r_from_mem;
    logic                r_shared;
    logic                r_timeout;

    logic [NCORES-1:0]   w_eligible;
    logic                w_found;
    logic [ID_W-1:0]     w_pick;
    logic [1:0]          w_sel_type;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [NCORES-1:0]   w_new_ack;
    logic [NCORES-1:0]   w_ack_all;
    logic [NCORES-1:0]   w_hit_all;
    logic [NCORES-1:0]   w_prov_all;
    logic                w_all_acked;
    logic [7:0]          w_cnt_next;
    logic                w_expired;
    logic [ID_W-1:0]     w_lowest;

    // A type of 00 means the core has nothing to arbitrate for.
    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < NCORES; i++) begin
            w_eligible[i] = bus.req_valid[i] && (bus.req_type[2*i +: 2] != 2'b00);
        end
    end

    // Round-robin search starting one past the last granted core.
    always_comb begin : rr_pick
        logic [ID_W-1:0] w_idx;
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 1; k <= NCORES; k++) begin
            w_idx = ID_W'((int'(r_last) + k) % NCORES);
            if (!w_found && w_eligible[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_comb begin
        w_sel_type = 2'b00;
        w_sel_addr = '0;
        for (int i = 0; i < NCORES; i++) begin
            if (w_pick == ID_W'(i)) begin
                w_sel_type = bus.req_type[2*i +: 2];
                w_sel_addr = bus.req_addr[ADDR_W*i +: ADDR_W];
            end
        end
    end

    // Only the first ack from each masked core counts; hit/provide ride on it.
    assign w_new_ack   = bus.snoop_ack & r_mask & ~r_ack;
    assign w_ack_all   = r_ack  | w_new_ack;
    assign w_hit_all   = r_hit  | (bus.snoop_hit     & w_new_ack);
    assign w_prov_all  = r_prov | (bus.snoop_provide & w_new_ack);
    assign w_all_acked = (w_ack_all == r_mask);
    assign w_cnt_next  = r_cnt + 8'd1;
    assign w_expired   = (w_cnt_next == TIMEOUT_CNT);

    always_comb begin
        w_lowest = '0;
        for (int i = NCORES - 1; i >= 0; i--) begin
            if (w_prov_all[i]) begin
                w_lowest = ID_W'(i);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_found) w_state_next = ST_SNOOP;
            ST_SNOOP: if (w_all_acked || w_expired) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Grant and completion strobes default low so each is a single-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_winner     <= '0;
            r_last       <= ID_W'(NCORES - 1);
            r_type       <= 2'b00;
            r_addr       <= '0;
            r_mask       <= '0;
            r_ack        <= '0;
            r_hit        <= '0;
            r_prov       <= '0;
            r_cnt        <= '0;
            r_grant      <= '0;
            r_done_valid <= '0;
            r_supplier   <= '0;
            r_from_mem   <= 1'b0;
            r_shared     <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_grant      <= '0;
            r_done_valid <= '0;
            r_supplier   <= '0;
            r_from_mem   <= 1'b0;
            r_shared     <= 1'b0;
            r_timeout    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_winner <= w_pick;
                        r_type   <= w_sel_type;
                        r_addr   <= w_sel_addr;
                        r_mask   <= ~(NCORES'(1) << w_pick);
                        r_ack    <= '0;
                        r_hit    <= '0;
                        r_prov   <= '0;
                        r_cnt    <= '0;
                        r_grant  <= NCORES'(1) << w_pick;
                    end
                end
                ST_SNOOP: begin
                    r_ack  <= w_ack_all;
                    r_hit  <= w_hit_all;
                    r_prov <= w_prov_all;
                    r_cnt  <= w_cnt_next;
                    if (w_all_acked || w_expired) begin
                        r_done_valid <= NCORES'(1) << r_winner;
                        r_supplier   <= (r_type == TYPE_UPGRADE) ? '0 : w_lowest;
                        r_from_mem   <= (r_type != TYPE_UPGRADE) && (w_prov_all == '0);
                        r_shared     <= (r_type == TYPE_READ) && (w_hit_all != '0);
                        // A full set of acks on the final cycle is a normal completion.
                        r_timeout    <= !w_all_acked;
                        r_last       <= r_winner;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req_grant     = r_grant;
    assign bus.snoop_valid   = (r_state == ST_SNOOP);
    assign bus.snoop_type    = r_type;
    assign bus.snoop_addr    = r_addr;
    assign bus.snoop_mask    = r_mask;
    assign bus.done_valid    = r_done_valid;
    assign bus.done_supplier = r_supplier;
    assign bus.done_from_mem = r_from_mem;
    assign bus.done_shared   = r_shared;
    assign bus.done_timeout  = r_timeout;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// tb_snoop_bus_arbiter
// Directed-vector bench for snoop_bus_arbiter (NCORES=4, ADDR_W=64,
// SNOOP_TIMEOUT=15). A transaction-level reference model predicts the
// outputs each cycle and a compare process checks them at every falling
// edge; directed scenarios add hand-computed literal expectations.
module tb_snoop_bus_arbiter;
    localparam int NC      = 4;
    localparam int AW      = 64;
    localparam int TIMEOUT = 15;

    localparam logic [1:0] READ    = 2'b01;
    localparam logic [1:0] UPGRADE = 2'b11;

    logic clk = 1'b0;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    snoop_bus_arbiter_if #(.NCORES(NC), .ADDR_W(AW)) bus ();

    snoop_bus_arbiter #(
        .NCORES(NC),
        .ADDR_W(AW),
        .SNOOP_TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: one open transaction at most.
    int         stage     = 0;   // 0 waiting for requests, 1 snooping, 2 completing
    int         lastGrant = NC - 1;
    int         txCore    = 0;
    logic [1:0] txType    = 2'b00;
    logic [63:0] txAddr   = '0;
    int         age       = 0;
    logic [3:0] acked     = '0;
    logic [3:0] hitSeen   = '0;
    logic [3:0] provSeen  = '0;

    logic [3:0] eGrant    = '0;
    logic [3:0] eDone     = '0;
    logic [1:0] eSupplier = '0;
    logic       eFromMem  = 1'b0;
    logic       eShared   = 1'b0;
    logic       eTimeout  = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [7:0] types,
                                 input logic [3:0] ack, input logic [3:0] hit,
                                 input logic [3:0] prov);
        bus.req_valid     = valid;
        bus.req_type      = types;
        bus.snoop_ack     = ack;
        bus.snoop_hit     = hit;
        bus.snoop_provide = prov;
    endtask

    task automatic resetModel();
        stage     = 0;
        lastGrant = NC - 1;
        eGrant    = '0;
        eDone     = '0;
        eSupplier = '0;
        eFromMem  = 1'b0;
        eShared   = 1'b0;
        eTimeout  = 1'b0;
    endtask

    // Reference model, advanced on every rising edge from the sampled inputs.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                resetModel();
            end else begin
                logic [7:0]  tmpType;
                logic [255:0] tmpAddr;
                bit          allIn;
                bit          picked;
                int          c;
                eGrant = '0;
                if (stage == 2) begin
                    eDone = '0; eSupplier = '0; eFromMem = 0; eShared = 0; eTimeout = 0;
                    stage = 0;
                end else if (stage == 1) begin
                    age++;
                    for (int i = 0; i < NC; i++) begin
                        if (i != txCore && bus.snoop_ack[i] && !acked[i]) begin
                            acked[i] = 1'b1;
                            if (bus.snoop_hit[i])     hitSeen[i]  = 1'b1;
                            if (bus.snoop_provide[i]) provSeen[i] = 1'b1;
                        end
                    end
                    allIn = 1;
                    for (int i = 0; i < NC; i++) begin
                        if (i != txCore && !acked[i]) allIn = 0;
                    end
                    if (allIn || age == TIMEOUT) begin
                        eDone = 4'(32'd1 << txCore);
                        eSupplier = '0;
                        for (int i = NC - 1; i >= 0; i--) begin
                            if (provSeen[i]) eSupplier = 2'(i);
                        end
                        if (txType == UPGRADE) eSupplier = '0;
                        eFromMem  = (txType != UPGRADE) && (provSeen == 4'b0000);
                        eShared   = (txType == READ) && (hitSeen != 4'b0000);
                        eTimeout  = !allIn;
                        lastGrant = txCore;
                        stage     = 2;
                    end
                end else begin
                    picked = 0;
                    c = 0;
                    for (int k = 1; k <= NC; k++) begin
                        int cand;
                        cand = (lastGrant + k) % NC;
                        tmpType = bus.req_type >> (2 * cand);
                        if (!picked && bus.req_valid[cand] && tmpType[1:0] != 2'b00) begin
                            picked = 1;
                            c = cand;
                        end
                    end
                    if (picked) begin
                        tmpType  = bus.req_type >> (2 * c);
                        tmpAddr  = bus.req_addr >> (AW * c);
                        txCore   = c;
                        txType   = tmpType[1:0];
                        txAddr   = tmpAddr[63:0];
                        acked    = '0;
                        hitSeen  = '0;
                        provSeen = '0;
                        age      = 0;
                        eGrant   = 4'(32'd1 << c);
                        stage    = 1;
                    end
                end
            end
        end
    end

    // Compare process: every falling edge, DUT against the model.
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("req_grant", 64'(bus.req_grant), 64'(eGrant));
            checkOutput("snoop_valid", 64'(bus.snoop_valid), 64'(stage == 1));
            checkOutput("done_valid", 64'(bus.done_valid), 64'(eDone));
            if (stage == 1) begin
                checkOutput("snoop_type", 64'(bus.snoop_type), 64'(txType));
                checkOutput("snoop_addr", bus.snoop_addr, txAddr);
                checkOutput("snoop_mask", 64'(bus.snoop_mask), 64'(4'(~(32'd1 << txCore))));
            end
            if (eDone != 4'b0000) begin
                checkOutput("done_supplier", 64'(bus.done_supplier), 64'(eSupplier));
                checkOutput("done_from_mem", 64'(bus.done_from_mem), 64'(eFromMem));
                checkOutput("done_shared", 64'(bus.done_shared), 64'(eShared));
                checkOutput("done_timeout", 64'(bus.done_timeout), 64'(eTimeout));
            end
        end
    end

    task automatic waitGrant(output int core);
        core = -1;
        for (int n = 0; n < 40; n++) begin
            if (bus.req_grant != 4'b0000) break;
            @(negedge clk);
        end
        checks++;
        if (bus.req_grant == 4'b0000) begin
            errors++;
            $display("[TB] FAIL grant_wait actual=none required=grant within 40 cycles");
        end else begin
            for (int i = 0; i < NC; i++) if (bus.req_grant[i]) core = i;
        end
    endtask

    task automatic waitDone(output int snoopCycles);
        snoopCycles = 0;
        for (int n = 0; n < 60; n++) begin
            if (bus.done_valid != 4'b0000) break;
            if (bus.snoop_valid) snoopCycles++;
            @(negedge clk);
        end
        checks++;
        if (bus.done_valid == 4'b0000) begin
            errors++;
            $display("[TB] FAIL done_wait actual=none required=done within 60 cycles");
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=still running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int core;
        int cyc;
        int rrExp[5] = '{0, 1, 2, 3, 0};

        bus.req_addr = {64'hFFFF_FFFF_FFFF_FFC0, 64'h0000_0000_0000_1000,
                        64'h0000_0000_0000_0080, 64'hA000_0000_0000_0040};
        applyStimulus(4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0000);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("rst_grant", 64'(bus.req_grant), 64'h0);
        checkOutput("rst_snoop_valid", 64'(bus.snoop_valid), 64'h0);
        checkOutput("rst_snoop_addr", bus.snoop_addr, 64'h0);
        checkOutput("rst_snoop_mask", 64'(bus.snoop_mask), 64'h0);
        checkOutput("rst_done_valid", 64'(bus.done_valid), 64'h0);
        checkOutput("rst_done_from_mem", 64'(bus.done_from_mem), 64'h0);

        // Core 2 READ, core 1 supplies and holds the line
        rst_n = 1'b1;
        applyStimulus(4'b0100, 8'b00_01_00_00, 4'b0000, 4'b0000, 4'b0000);
        @(negedge clk);
        checkOutput("t1_grant", 64'(bus.req_grant), 64'h4);
        checkOutput("t1_mask", 64'(bus.snoop_mask), 64'hB);
        checkOutput("t1_addr", bus.snoop_addr, 64'h1000);
        applyStimulus(4'b0000, 8'h00, 4'b1011, 4'b0010, 4'b0010);
        @(negedge clk);
        checkOutput("t1_done", 64'(bus.done_valid), 64'h4);
        checkOutput("t1_supplier", 64'(bus.done_supplier), 64'h1);
        checkOutput("t1_from_mem", 64'(bus.done_from_mem), 64'h0);
        checkOutput("t1_shared", 64'(bus.done_shared), 64'h1);
        applyStimulus(4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0000);

        // All cores WRITE continuously from reset: round-robin 0,1,2,3,0
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'b1111, 8'b10_10_10_10, 4'b1111, 4'b0000, 4'b0000);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            waitGrant(core);
            checkOutput("rr_order", 64'(core), 64'(rrExp[j]));
            checkOutput("rr_mask", 64'(bus.snoop_mask), 64'(4'(~(32'd1 << rrExp[j]))));
            if (j == 4) applyStimulus(4'b0000, 8'h00, 4'b1111, 4'b0000, 4'b0000);
        end
        @(negedge clk);
        waitDone(cyc);
        checkOutput("rr_from_mem", 64'(bus.done_from_mem), 64'h1);
        applyStimulus(4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0000);
        @(negedge clk);

        // Core 0 UPGRADE: no data movement, never shared
        applyStimulus(4'b0001, 8'b00_00_00_11, 4'b1111, 4'b1110, 4'b0000);
        @(negedge clk);
        waitGrant(core);
        checkOutput("upg_core", 64'(core), 64'h0);
        applyStimulus(4'b0000, 8'h00, 4'b1111, 4'b1110, 4'b0000);
        @(negedge clk);
        checkOutput("upg_done", 64'(bus.done_valid), 64'h1);
        checkOutput("upg_from_mem", 64'(bus.done_from_mem), 64'h0);
        checkOutput("upg_shared", 64'(bus.done_shared), 64'h0);
        checkOutput("upg_supplier", 64'(bus.done_supplier), 64'h0);
        applyStimulus(4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0000);
        @(negedge clk);

        // Core 3 READ, core 2 never acks: forced completion
        applyStimulus(4'b1000, 8'b01_00_00_00, 4'b0011, 4'b0011, 4'b0000);
        @(negedge clk);
        waitGrant(core);
        checkOutput("to_core", 64'(core), 64'h3);
        checkOutput("to_addr", bus.snoop_addr, 64'hFFFF_FFFF_FFFF_FFC0);
        applyStimulus(4'b0000, 8'h00, 4'b0011, 4'b0011, 4'b0000);
        waitDone(cyc);
        checkOutput("to_snoop_cycles", 64'(cyc), 64'd15);
        checkOutput("to_timeout", 64'(bus.done_timeout), 64'h1);
        checkOutput("to_from_mem", 64'(bus.done_from_mem), 64'h1);
        checkOutput("to_shared", 64'(bus.done_shared), 64'h1);
        applyStimulus(4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0000);
        @(negedge clk);

        // Core 1 READ, staggered acks with a duplicate and a requester ack
        applyStimulus(4'b0010, 8'b00_00_01_00, 4'b0000, 4'b0000, 4'b0000);
        @(negedge clk);
        waitGrant(core);
        checkOutput("stag_core", 64'(core), 64'h1);
        applyStimulus(4'b0000, 8'h00, 4'b0011, 4'b0010, 4'b0010);
        @(negedge clk);
        checkOutput("stag_done_c2", 64'(bus.done_valid), 64'h0);
        applyStimulus(4'b0000, 8'h00, 4'b0001, 4'b0001, 4'b0001);
        @(negedge clk);
        checkOutput("stag_done_c3", 64'(bus.done_valid), 64'h0);
        applyStimulus(4'b0000, 8'h00, 4'b0100, 4'b0000, 4'b0000);
        @(negedge clk);
        checkOutput("stag_done_c4", 64'(bus.done_valid), 64'h0);
        checkOutput("stag_snoop_c4", 64'(bus.snoop_valid), 64'h1);
        applyStimulus(4'b0000, 8'h00, 4'b1000, 4'b1000, 4'b1000);
        @(negedge clk);
        checkOutput("stag_done", 64'(bus.done_valid), 64'h2);
        checkOutput("stag_supplier", 64'(bus.done_supplier), 64'h3);
        checkOutput("stag_shared", 64'(bus.done_shared), 64'h1);
        checkOutput("stag_timeout", 64'(bus.done_timeout), 64'h0);
        applyStimulus(4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0000);
        @(negedge clk);

        // Reset during SNOOP aborts; core 0 regains first priority
        applyStimulus(4'b0100, 8'b00_01_00_00, 4'b0000, 4'b0000, 4'b0000);
        @(negedge clk);
        waitGrant(core);
        checkOutput("abort_first_core", 64'(core), 64'h2);
        applyStimulus(4'b0101, 8'b00_01_00_01, 4'b0000, 4'b0000, 4'b0000);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_grant", 64'(bus.req_grant), 64'h0);
        checkOutput("abort_snoop_valid", 64'(bus.snoop_valid), 64'h0);
        checkOutput("abort_snoop_type", 64'(bus.snoop_type), 64'h0);
        checkOutput("abort_snoop_addr", bus.snoop_addr, 64'h0);
        checkOutput("abort_snoop_mask", 64'(bus.snoop_mask), 64'h0);
        checkOutput("abort_done", 64'(bus.done_valid), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        waitGrant(core);
        checkOutput("abort_regrant", 64'(core), 64'h0);
        applyStimulus(4'b0100, 8'b00_01_00_00, 4'b1110, 4'b0000, 4'b0000);
        @(negedge clk);
        checkOutput("abort_done_c0", 64'(bus.done_valid), 64'h1);
        applyStimulus(4'b0000, 8'h00, 4'b0000, 4'b0000, 4'b0000);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
